// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: run-control for the 7-stage 8X-RIPTIDE pipeline.
// Owns issue, drain, halt and single-step sequencing, and tracks one valid
// token per pipeline stage (stage 1 = index 0).
// Optional performance counters are built only when RIPTIDE_PERF_CNT_EN is
// defined; otherwise stall_cnt/flush_cnt are constant zero.
//
// Flow-control contract: hazard is the inverse of "ready" for stage 1. An
// instruction enters stage 1 (issue=1) only in a cycle where the sequencer
// wants one (RUN, or STEP before its single issue) AND hazard=0 AND no
// redirect is in progress. pipeline_flush always loads the PC (pc_en=1)
// except while still in BOOT.
module pipeline_sequencer #(
  parameter int DEPTH       = 7,
  parameter int FLUSH_STAGE = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             n_RST,
  input  logic             hazard,
  input  logic             pipeline_flush,
  input  logic             halt_req,
  input  logic             step_req,
  output logic             pc_en,
  output logic             issue,
  output logic [DEPTH-1:0] stage_valid,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN  = 3'd2,
    S_HALTED = 3'd3,
    S_STEP   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] w_valid_next;
  logic             r_halted;
  logic             w_issue;
  logic             w_pc_en;
  logic             w_empty;

  assign w_empty = (r_valid == '0);

  // State register; reset discards every token and the halted flag at once.
  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and issue/pc_en decode. STEP leaves on the cycle it issues,
  // so "STEP not yet issued" is simply "in STEP".
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_pc_en = 1'b0;
    if ((r_state == S_RUN) || (r_state == S_STEP)) begin
      w_issue = ~hazard & ~pipeline_flush;
    end
    // Redirects load the PC in every state except BOOT.
    w_pc_en = w_issue | (pipeline_flush & (r_state != S_BOOT));
    case (r_state)
      S_BOOT: begin
        w_next = S_RUN;
      end
      S_RUN: begin
        if (halt_req) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!halt_req) begin
          w_next = S_RUN;
        end else if (w_empty) begin
          w_next = S_HALTED;
        end
      end
      S_HALTED: begin
        // Releasing halt wins over a coincident step request.
        if (!halt_req) begin
          w_next = S_RUN;
        end else if (step_req) begin
          w_next = S_STEP;
        end
      end
      S_STEP: begin
        if (w_issue) begin
          w_next = halt_req ? S_DRAIN : S_RUN;
        end
      end
      default: begin
        w_next = S_BOOT;
      end
    endcase
  end

  // Next token vector: shift toward the oldest stage, then apply the
  // flush kill or the hazard hold/bubble. Flush overrides the hazard hold.
  always_comb begin
    w_valid_next = {r_valid[DEPTH-2:0], w_issue};
    if (pipeline_flush) begin
      for (int i = 0; i < FLUSH_STAGE - 1; i++) begin
        w_valid_next[i] = 1'b0;
      end
    end else if (hazard) begin
      w_valid_next[0] = r_valid[0];
      w_valid_next[1] = 1'b0;
    end
  end

  // Token register; the oldest token falls off the top each cycle.
  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_next;
    end
  end

  // Halted status is registered: it rises one cycle after HALTED is entered
  // and drops on the edge that leaves HALTED.
  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      r_halted <= 1'b0;
    end else begin
      r_halted <= (r_state == S_HALTED) && (w_next == S_HALTED);
    end
  end

`ifdef RIPTIDE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_inc;

  assign w_stall_inc = hazard & ~pipeline_flush &
                       ((r_state == S_RUN) || (r_state == S_STEP));

  // Saturating stall counter: only stalls that block a wanted issue count.
  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      r_stall_cnt <= '0;
    end else if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Saturating flush counter: every redirect counts.
  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      r_flush_cnt <= '0;
    end else if (pipeline_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
      r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  assign issue       = w_issue;
  assign pc_en       = w_pc_en;
  assign stage_valid = r_valid;
  assign halted      = r_halted;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Testbench for pipeline_sequencer: directed steps plus a randomized phase,
// all compared against a cycle-level reference model built from the
// run-control rules (token array, mode label, saturating integers).
module tb_pipeline_sequencer;
  localparam int DEPTH = 7;
  localparam int FS    = 4;
  localparam int CW    = 4;
  localparam int MAXC  = (1 << CW) - 1;
`ifdef RIPTIDE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Reference-model mode labels.
  localparam int M_BOOT = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3, M_STEP = 4;

  logic             clk = 1'b0;
  logic             n_RST = 1'b0;
  logic             hazard = 1'b0;
  logic             pipeline_flush = 1'b0;
  logic             halt_req = 1'b0;
  logic             step_req = 1'b0;
  logic             pc_en;
  logic             issue;
  logic [DEPTH-1:0] stage_valid;
  logic             halted;
  logic [CW-1:0]    stall_cnt;
  logic [CW-1:0]    flush_cnt;
  logic [2:0]       dbg_state;

  int checks = 0;
  int failures = 0;
  int issues_seen = 0;
  logic [DEPTH-1:0] exp_q[$];

  // Reference model state.
  bit m_tok[DEPTH];
  int m_mode;
  bit m_halted;
  int m_stall;
  int m_flush;
  bit e_issue;
  bit e_pcen;

  pipeline_sequencer #(.DEPTH(DEPTH), .FLUSH_STAGE(FS), .CNT_W(CW)) dut (
    .clk(clk), .n_RST(n_RST), .hazard(hazard), .pipeline_flush(pipeline_flush),
    .halt_req(halt_req), .step_req(step_req), .pc_en(pc_en), .issue(issue),
    .stage_valid(stage_valid), .halted(halted), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .dbg_state(dbg_state)
  );

  // Clock block.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DEPTH-1:0] m_vec();
    logic [DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = m_tok[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_tok[i] = 1'b0;
    m_mode = M_BOOT;
    m_halted = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // Combinational expectations from the current mode and inputs.
  task automatic model_comb(input bit h, input bit f);
    e_issue = ((m_mode == M_RUN) || (m_mode == M_STEP)) && !h && !f;
    e_pcen  = e_issue || (f && (m_mode != M_BOOT));
  endtask

  // Advance the model by one clock edge.
  task automatic model_clock(input bit h, input bit f, input bit hr, input bit sr);
    bit nt[DEPTH];
    bit any;
    int nm;
    any = 1'b0;
    for (int i = 0; i < DEPTH; i++) any |= m_tok[i];
    nt[0] = e_issue;
    for (int i = 1; i < DEPTH; i++) nt[i] = m_tok[i-1];
    if (f) begin
      for (int i = 0; i <= FS - 2; i++) nt[i] = 1'b0;
    end else if (h) begin
      nt[0] = m_tok[0];
      nt[1] = 1'b0;
    end
    nm = m_mode;
    if (m_mode == M_BOOT) nm = M_RUN;
    else if (m_mode == M_RUN) nm = hr ? M_DRAIN : M_RUN;
    else if (m_mode == M_DRAIN) nm = !hr ? M_RUN : (!any ? M_HALTED : M_DRAIN);
    else if (m_mode == M_HALTED) nm = !hr ? M_RUN : (sr ? M_STEP : M_HALTED);
    else if (m_mode == M_STEP) nm = e_issue ? (hr ? M_DRAIN : M_RUN) : M_STEP;
    if (PERF) begin
      if (h && !f && ((m_mode == M_RUN) || (m_mode == M_STEP)) && m_stall < MAXC) m_stall++;
      if (f && m_flush < MAXC) m_flush++;
    end
    m_halted = (m_mode == M_HALTED) && (nm == M_HALTED);
    m_mode = nm;
    for (int i = 0; i < DEPTH; i++) m_tok[i] = nt[i];
  endtask

  // Driver: called just after a falling edge. Applies inputs, checks all
  // outputs against the model mid-low-phase, then clocks model and DUT.
  task automatic cyc(input bit h, input bit f, input bit hr, input bit sr);
    hazard = h;
    pipeline_flush = f;
    halt_req = hr;
    step_req = sr;
    #1;
    model_comb(h, f);
    exp_q.push_back(m_vec());
    chk("issue", 32'(issue), 32'(e_issue));
    chk("pc_en", 32'(pc_en), 32'(e_pcen));
    chk("stage_valid", 32'(stage_valid), 32'(exp_q.pop_front()));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    if (issue === 1'b1) issues_seen++;
    @(posedge clk);
    model_clock(h, f, hr, sr);
    @(negedge clk);
  endtask

  initial begin
    bit hr_r;
    model_reset();
    #2;
    chk("rst_valid", 32'(stage_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_pc_en", 32'(pc_en), 32'h0);
    chk("rst_issue", 32'(issue), 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    chk("rst_flush", 32'(flush_cnt), 32'h0);
    @(negedge clk);
    n_RST = 1'b1;

    // BOOT cycle plus 7 issuing cycles fill the pipe.
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
    chk("fill", 32'(stage_valid), 32'h7F);

    // Two stall cycles: index 0 held, bubbles enter at index 1.
    cyc(1, 0, 0, 0);
    chk("stall1", 32'(stage_valid), 32'h7D);
    cyc(1, 0, 0, 0);
    chk("stall2", 32'(stage_valid), 32'h79);
    chk("stall_cnt2", 32'(stall_cnt), PERF ? 32'd2 : 32'd0);
    cyc(0, 0, 0, 0);
    chk("stall_after", 32'(stage_valid), 32'h73);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    chk("refill", 32'(stage_valid), 32'h7F);

    // Redirect kills stages 1..3.
    cyc(0, 1, 0, 0);
    chk("flush_kill", 32'(stage_valid), 32'h78);
    chk("flush_cnt1", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0);
    chk("refill2", 32'(stage_valid), 32'h7F);

    // Halt with a full pipe: drain, then halted.
    for (int i = 0; i < 11; i++) cyc(0, 0, 1, 0);
    chk("halt_empty", 32'(stage_valid), 32'h0);
    chk("halt_flag", 32'(halted), 32'h1);

    // Single step: exactly one issue, then halted again.
    issues_seen = 0;
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0);
    chk("step_issues", 32'(issues_seen), 32'd1);
    chk("step_halted", 32'(halted), 32'h1);

    // Step held off by hazard, with step_req asserted outside HALTED too.
    cyc(1, 0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0);

    // Release halt.
    cyc(0, 0, 0, 0);
    chk("resume_issue", 32'(issue), 32'h1);

    // Randomized phase.
    hr_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) hr_r = ~hr_r;
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, hr_r,
          $urandom_range(0, 5) == 0);
    end

    // Saturation of the stall counter.
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0);
    chk("stall_sat", 32'(stall_cnt), PERF ? 32'hF : 32'h0);

    // Build 7'h55 then reset mid-run.
    n_RST = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    n_RST = 1'b1;
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, (i % 2) == 0, 0);
    chk("pre_rst", 32'(stage_valid), 32'h55);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    #1;
    n_RST = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_valid", 32'(stage_valid), 32'h0);
    chk("mid_rst_halted", 32'(halted), 32'h0);
    chk("mid_rst_pc_en", 32'(pc_en), 32'h0);
    chk("mid_rst_stall", 32'(stall_cnt), 32'h0);
    chk("mid_rst_flush", 32'(flush_cnt), 32'h0);
    @(negedge clk);
    n_RST = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);

    // Final report.
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
